dose_confirm_monitor: RTL and testbench
=======================================

// Module: dose_confirm_monitor
// PURPOSE
//  Return path of the dispenser GPIO interface: samples the pill-drop sensor on the
//  dispenser mechanism and confirms that each dispense pulse actually delivered a dose.
//  Sits beside the dispense pulse generator; the monitored input is the same level that
//  drives the GPIO dispense port. Reports per-dose success/miss to the alert logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000     cycles sensor must be stable before level is accepted (10 ms @50 MHz)
//  TIMEOUT_CYCLES   150000000  cycles after dispense rising edge before dose is declared missed (3 s)
//  MISS_W           8          width of saturating miss counter
// PORTS
//  clock          in   1       system clock, 50 MHz
//  resetn         in   1       asynchronous, active-low reset
//  dispense_port  in   1       dispense drive level (high while mechanism is actuated)
//  sensor_raw     in   1       asynchronous pill-drop sensor, active high, bouncy
//  slot           in   2       dose slot: 0 morning, 1 afternoon, 2 evening; 3 invalid
//  ack_clear      in   1       one-cycle pulse: clear missed_flags and miss_count
//  sensor_level   out  1       debounced sensor level
//  busy           out  1       high in any state other than IDLE
//  dose_ok        out  1       one-cycle pulse: drop detected within timeout
//  dose_missed    out  1       one-cycle pulse: timeout expired without drop
//  missed_flags   out  3       sticky per-slot miss flags, bit index = latched slot
//  miss_count     out  MISS_W  saturating count of missed doses
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, timers 0, synchronizer and debounce state 0. Applies mid-operation.
//  Input conditioning: sensor_raw passes through a 2-flop synchronizer. sensor_level changes only after
//   the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free
//   cycle restarts the count. dispense_port is registered once for edge detection.
//  Edge events: disp_rise = port & ~port_q; drop = sensor_level rising (level & ~level_q).
//  FSM states: IDLE, ARMED, HOLDOFF.
//   IDLE:    on disp_rise -> ARMED; latch slot; clear timer. drop in IDLE is ignored.
//   ARMED:   timer increments every cycle.
//            drop -> dose_ok=1 next cycle, -> HOLDOFF.
//            timer == TIMEOUT_CYCLES-1 with no drop -> dose_missed=1, set missed_flags[slot_q]
//            (not set if slot_q==3), miss_count+1 saturating at all-ones, -> HOLDOFF.
//            drop and timeout in same cycle: drop wins (dose_ok only).
//            disp_rise while ARMED is ignored (no re-arm, timer not restarted).
//   HOLDOFF: stay until dispense_port==0 AND sensor_level==0, then -> IDLE. disp_rise ignored.
//  Latency: dose_ok/dose_missed registered, asserted exactly one cycle, the cycle after the
//   deciding event. Sensor edge to dose_ok = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  ack_clear: clears missed_flags and miss_count next cycle. If a miss is recorded in the same
//   cycle, clear applies first, then the miss: result flag set for that slot, count = 1.
//  busy = (state != IDLE), registered with state.
//  Timer width = $clog2(TIMEOUT_CYCLES); debounce counter width = $clog2(DEBOUNCE_CYCLES+1).
// STRUCTURE
//  dispenser_pkg: FSM state encoding (IDLE/ARMED/HOLDOFF), slot constants SLOT_MORNING=0,
//   SLOT_AFTERNOON=1, SLOT_EVENING=2, default timing constants for 50 MHz.
//  Sub-module: sensor_debounce (synchronizer + debounce counter, outputs sensor_level).
//  Top holds edge detect, FSM, timeout timer, flags and counter.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
//  Normal dose: slot=1, port high 30 cyc, clean sensor high at cycle 5 -> one dose_ok, flags=000, count=0.
//  Timeout: slot=2, port pulse, no sensor -> dose_missed on cycle 21 after edge, flags=100, count=1.
//  Bounce: sensor toggles every 2 cycles for 10 cycles, then stable -> single drop, one dose_ok only.
//  Tie/saturation: drop at timer=19 -> dose_ok, no miss; MISS_W=2, 5 misses -> count stays 3.
//  Clear collision: ack_clear same cycle as miss on slot 0 -> flags=001, count=1.
//  Reset mid-ARMED: resetn low 2 cycles at timer=10 -> busy=0, no pulses, flags/count 0; new edge re-arms.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared definitions for the dispenser GPIO return path.
//   dose_state_e    : dose-confirmation FSM states
//   SLOT_*          : dose slot codes carried on the 2-bit slot bus
//   DEFAULT_*       : timing defaults for a 50 MHz system clock
package dispenser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } dose_state_e;

    localparam logic [1:0] SLOT_MORNING   = 2'd0;
    localparam logic [1:0] SLOT_AFTERNOON = 2'd1;
    localparam logic [1:0] SLOT_EVENING   = 2'd2;
    localparam logic [1:0] SLOT_INVALID   = 2'd3;

    // 10 ms debounce, 3 s drop timeout, 8-bit miss counter at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 150000000;
    localparam int unsigned DEFAULT_MISS_W          = 8;

endpackage

// File: rtl/sensor_debounce.sv
// Conditions the asynchronous, bouncy pill-drop sensor.
//   clock        : system clock
//   resetn       : asynchronous active-low reset
//   sensor_raw   : raw sensor input, active high, asynchronous
//   sensor_level : debounced level; follows the synchronized input only after it
//                  has disagreed for DEBOUNCE_CYCLES consecutive cycles
module sensor_debounce
    import dispenser_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic sensor_raw,
    output logic sensor_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_1       <= 1'b0;
            sync_2       <= 1'b0;
            stable_cnt   <= '0;
            sensor_level <= 1'b0;
        end else begin
            sync_1 <= sensor_raw;
            sync_2 <= sync_1;
            if (sync_2 != sensor_level) begin
                // This cycle is the DEBOUNCE_CYCLES-th consecutive disagreement
                if (stable_cnt == CNT_LAST) begin
                    sensor_level <= sync_2;
                    stable_cnt   <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dose_confirm_monitor.sv
// Confirms that each dispense pulse actually delivered a dose.
//   clock          : system clock, 50 MHz
//   resetn         : asynchronous active-low reset
//   dispense_port  : dispense drive level, high while the mechanism is actuated
//   sensor_raw     : asynchronous pill-drop sensor, active high, bouncy
//   slot           : dose slot (0 morning, 1 afternoon, 2 evening, 3 invalid)
//   ack_clear      : one-cycle pulse clearing missed_flags and miss_count
//   sensor_level   : debounced sensor level
//   busy           : high whenever the FSM is not IDLE
//   dose_ok        : one-cycle pulse, drop seen within the timeout
//   dose_missed    : one-cycle pulse, timeout expired without a drop
//   missed_flags   : sticky per-slot miss flags, indexed by the latched slot
//   miss_count     : saturating count of missed doses
module dose_confirm_monitor
    import dispenser_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned MISS_W          = DEFAULT_MISS_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              dispense_port,
    input  logic              sensor_raw,
    input  logic [1:0]        slot,
    input  logic              ack_clear,
    output logic              sensor_level,
    output logic              busy,
    output logic              dose_ok,
    output logic              dose_missed,
    output logic [2:0]        missed_flags,
    output logic [MISS_W-1:0] miss_count
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    dose_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         slot_q, slot_d;
    logic               port_q;
    logic               level_q;
    logic               disp_rise;
    logic               drop;
    logic               ok_d;
    logic               missed_d;
    logic [2:0]         flags_d;
    logic [MISS_W-1:0]  count_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sensor_debounce (
        .clock        (clock),
        .resetn       (resetn),
        .sensor_raw   (sensor_raw),
        .sensor_level (sensor_level)
    );

    assign disp_rise = dispense_port & ~port_q;
    assign drop      = sensor_level & ~level_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            slot_q       <= '0;
            port_q       <= 1'b0;
            level_q      <= 1'b0;
            busy         <= 1'b0;
            dose_ok      <= 1'b0;
            dose_missed  <= 1'b0;
            missed_flags <= '0;
            miss_count   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            slot_q       <= slot_d;
            port_q       <= dispense_port;
            level_q      <= sensor_level;
            busy         <= (state_d != ST_IDLE);
            dose_ok      <= ok_d;
            dose_missed  <= missed_d;
            missed_flags <= flags_d;
            miss_count   <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        slot_d   = slot_q;
        ok_d     = 1'b0;
        missed_d = 1'b0;
        // Clear first so a miss recorded in the same cycle survives the clear
        flags_d  = ack_clear ? '0 : missed_flags;
        count_d  = ack_clear ? '0 : miss_count;

        unique case (state_q)
            ST_IDLE: begin
                if (disp_rise) begin
                    state_d = ST_ARMED;
                    slot_d  = slot;
                    timer_d = '0;
                end
            end
            ST_ARMED: begin
                timer_d = timer_q + 1'b1;
                // A drop on the final timer cycle still counts as delivered
                if (drop) begin
                    ok_d    = 1'b1;
                    state_d = ST_HOLDOFF;
                end else if (timer_q == TIMER_LAST) begin
                    missed_d = 1'b1;
                    state_d  = ST_HOLDOFF;
                    if (slot_q != SLOT_INVALID) begin
                        flags_d[slot_q] = 1'b1;
                    end
                    if (count_d != '1) begin
                        count_d = count_d + 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!dispense_port && !sensor_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dose_confirm_monitor.sv
module tb_dose_confirm_monitor;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TMO  = 20;
    localparam int unsigned MW   = 2;
    localparam int          CMAX = (1 << MW) - 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          dispense_port;
    logic          sensor_raw;
    logic [1:0]    slot;
    logic          ack_clear;
    logic          sensor_level;
    logic          busy;
    logic          dose_ok;
    logic          dose_missed;
    logic [2:0]    missed_flags;
    logic [MW-1:0] miss_count;

    always #5 clock = ~clock;

    dose_confirm_monitor #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO),
        .MISS_W          (MW)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .dispense_port (dispense_port),
        .sensor_raw    (sensor_raw),
        .slot          (slot),
        .ack_clear     (ack_clear),
        .sensor_level  (sensor_level),
        .busy          (busy),
        .dose_ok       (dose_ok),
        .dose_missed   (dose_missed),
        .missed_flags  (missed_flags),
        .miss_count    (miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the monitor should report, tracked per clock
    logic m_s1, m_s2, m_level, m_level_q, m_port_q;
    bit   m_hist[$];      // most recent synchronized samples, newest last
    bit   m_waiting;      // a dispense is pending confirmation
    bit   m_settling;     // confirmation decided, waiting for port and sensor to go low
    int   m_elapsed;      // whole cycles spent waiting since the dispense edge
    logic [1:0] m_slot;
    logic m_ok, m_miss, m_busy;
    logic [2:0] m_flags;
    int   m_count;

    // Per-scenario observations
    int iter, ok_cnt, miss_cnt, ok_at, miss_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_level_q = 0; m_port_q = 0;
        m_hist.delete();
        m_waiting = 0; m_settling = 0; m_elapsed = 0; m_slot = 0;
        m_ok = 0; m_miss = 0; m_busy = 0; m_flags = 0; m_count = 0;
    endtask

    task automatic model_step(input logic port, input logic raw, input logic [1:0] sl,
                              input logic ack);
        bit   drop, rise, flip;
        logic new_level;
        drop = m_level && !m_level_q;
        rise = port && !m_port_q;

        // Level flips once the last DEB synchronized samples all disagree with it
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        flip = (m_hist.size() == DEB);
        foreach (m_hist[k]) if (m_hist[k] == m_level) flip = 0;
        new_level = flip ? !m_level : m_level;

        m_ok = 0; m_miss = 0;
        if (ack) begin m_flags = 0; m_count = 0; end
        if (m_waiting) begin
            if (drop) begin
                m_ok = 1; m_waiting = 0; m_settling = 1;
            end else if (m_elapsed == TMO - 1) begin
                m_miss = 1; m_waiting = 0; m_settling = 1;
                if (m_slot != 2'd3) m_flags[m_slot] = 1'b1;
                if (m_count < CMAX) m_count = m_count + 1;
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end else if (m_settling) begin
            if (!port && !m_level) m_settling = 0;
        end else if (rise) begin
            m_waiting = 1; m_elapsed = 0; m_slot = sl;
        end
        m_busy = m_waiting || m_settling;

        m_s2 = m_s1; m_s1 = raw;
        m_level_q = m_level; m_level = new_level;
        m_port_q = port;
    endtask

    task automatic cyc(input logic port, input logic raw, input logic [1:0] sl,
                       input logic ack, input logic rstn);
        @(negedge clock);
        dispense_port = port; sensor_raw = raw; slot = sl; ack_clear = ack; resetn = rstn;
        @(posedge clock);
        if (!rstn) model_reset();
        else model_step(port, raw, sl, ack);
        #1;
        check("sensor_level", 32'(sensor_level), 32'(m_level));
        check("busy",         32'(busy),         32'(m_busy));
        check("dose_ok",      32'(dose_ok),      32'(m_ok));
        check("dose_missed",  32'(dose_missed),  32'(m_miss));
        check("missed_flags", 32'(missed_flags), 32'(m_flags));
        check("miss_count",   32'(miss_count),   32'(m_count));
        if (dose_ok === 1'b1)     begin ok_cnt++;   ok_at = iter;   end
        if (dose_missed === 1'b1) begin miss_cnt++; miss_at = iter; end
        iter++;
    endtask

    task automatic begin_scn();
        iter = 0; ok_cnt = 0; miss_cnt = 0; ok_at = -1; miss_at = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    logic       r_port, r_raw, r_ack, r_rstn;
    logic [1:0] r_slot;
    logic [1:0] sat_slots [5];

    initial begin
        resetn = 1'b0; dispense_port = 1'b0; sensor_raw = 1'b0; slot = 2'd0; ack_clear = 1'b0;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("rst_busy",  32'(busy), 0);
        check("rst_ok",    32'(dose_ok), 0);
        check("rst_miss",  32'(dose_missed), 0);
        check("rst_flags", 32'(missed_flags), 0);
        check("rst_count", 32'(miss_count), 0);
        check("rst_level", 32'(sensor_level), 0);
        idle(4);

        // Normal dose: slot 1, port high 30 cycles, clean sensor from cycle 5.
        // Iteration i's inputs are sampled at its edge; results show after it,
        // so 2 sync + DEB debounce + 1 register cycles land at iteration 5+2+DEB.
        begin_scn();
        for (int i = 0; i < 30; i++) cyc(1'b1, i >= 5, 2'd1, 1'b0, 1'b1);
        idle(10);
        check("norm_ok_cnt",   ok_cnt, 1);
        check("norm_latency",  ok_at, 5 + 2 + DEB);
        check("norm_miss_cnt", miss_cnt, 0);
        check("norm_flags",    32'(missed_flags), 0);
        check("norm_count",    32'(miss_count), 0);
        check("norm_idle",     32'(busy), 0);

        // Timeout: slot 2, short port pulse, no sensor
        begin_scn();
        for (int i = 0; i < 25; i++) cyc(i < 5, 1'b0, 2'd2, 1'b0, 1'b1);
        check("tmo_miss_cnt", miss_cnt, 1);
        check("tmo_when",     miss_at, TMO);
        check("tmo_ok_cnt",   ok_cnt, 0);
        check("tmo_flags",    32'(missed_flags), 32'b100);
        check("tmo_count",    32'(miss_count), 1);
        idle(3);

        // Bounce: toggles every 2 cycles for 10 cycles, then stable high
        begin_scn();
        for (int i = 0; i < 30; i++)
            cyc(i < 25, (i >= 1 && i <= 10) ? (((i - 1) / 2) % 2 == 0) : (i > 10 && i < 22),
                2'd0, 1'b0, 1'b1);
        idle(10);
        check("bnc_ok_cnt",   ok_cnt, 1);
        check("bnc_miss_cnt", miss_cnt, 0);

        // Tie: drop qualifies exactly when the timer reaches TMO-1
        begin_scn();
        for (int i = 0; i < 30; i++) cyc(i < 3, i >= 14 && i < 26, 2'd1, 1'b0, 1'b1);
        idle(10);
        check("tie_ok_cnt",   ok_cnt, 1);
        check("tie_when",     ok_at, TMO);
        check("tie_miss_cnt", miss_cnt, 0);
        check("tie_count",    32'(miss_count), 1);

        // Saturation: clear, then five misses including one on the invalid slot
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        check("clr_flags", 32'(missed_flags), 0);
        check("clr_count", 32'(miss_count), 0);
        sat_slots = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) begin
            begin_scn();
            for (int i = 0; i < 23; i++) cyc(i < 2, 1'b0, sat_slots[k], 1'b0, 1'b1);
            check("sat_miss_cnt", miss_cnt, 1);
            if (k == 3) check("sat_invalid_slot", 32'(missed_flags), 32'b111);
        end
        check("sat_count", 32'(miss_count), CMAX);
        check("sat_flags", 32'(missed_flags), 32'b111);

        // Clear collision: ack_clear on the same edge as a slot-0 miss
        begin_scn();
        for (int i = 0; i < 23; i++) cyc(i < 2, 1'b0, 2'd0, i == TMO, 1'b1);
        check("col_when",  miss_at, TMO);
        check("col_flags", 32'(missed_flags), 32'b001);
        check("col_count", 32'(miss_count), 1);

        // Reset while ARMED at timer 10, then a fresh edge re-arms
        begin_scn();
        for (int i = 0; i <= 10; i++) cyc(1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        check("mrst_busy",  32'(busy), 0);
        check("mrst_flags", 32'(missed_flags), 0);
        check("mrst_count", 32'(miss_count), 0);
        idle(25);
        check("mrst_no_miss", miss_cnt, 0);
        check("mrst_no_ok",   ok_cnt, 0);
        begin_scn();
        cyc(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
        check("rearm_busy", 32'(busy), 1);
        for (int i = 0; i < 22; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        check("rearm_miss_cnt", miss_cnt, 1);
        check("rearm_flags",    32'(missed_flags), 32'b010);

        // Randomized traffic against the model
        r_port = 1'b0; r_raw = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) r_port = ~r_port;
            if ($urandom_range(0, 7) == 0)  r_raw  = ~r_raw;
            r_slot = 2'($urandom_range(0, 3));
            r_ack  = ($urandom_range(0, 39) == 0);
            r_rstn = ($urandom_range(0, 799) != 0);
            cyc(r_port, r_raw, r_slot, r_ack, r_rstn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
